// File: rtl/eth_phy_10g_rx_gearbox_pkg.sv
// Shared widths, sync header codes and helpers for the 10G RX 64b->66b gearbox.
package eth_phy_10g_rx_gearbox_pkg;

  localparam int BLOCK_W   = 66;
  localparam int GB_DATA_W = 64;
  localparam int GB_HDR_W  = 2;
  localparam int FILL_W    = 7;
  localparam int TOT_W     = 8;
  localparam int COMB_W    = BLOCK_W + GB_DATA_W;

  localparam logic [GB_HDR_W-1:0] SYNC_DATA = 2'b10;
  localparam logic [GB_HDR_W-1:0] SYNC_CTRL = 2'b01;

  typedef logic [FILL_W-1:0] fill_t;

  function automatic logic [GB_DATA_W-1:0] bit_rev(input logic [GB_DATA_W-1:0] w);
    logic [GB_DATA_W-1:0] r;
    for (int i = 0; i < GB_DATA_W; i++) begin
      r[i] = w[GB_DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_gearbox.sv
// Raw 64-bit SERDES words in, 66-bit blocks (64b payload + 2b sync header) out,
// 32 blocks per 33 clocks, with one-bit-per-request bitslip for block lock.
module eth_phy_10g_rx_gearbox
  import eth_phy_10g_rx_gearbox_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data_in,
  input  logic                  serdes_rx_bitslip,
  output logic [DATA_WIDTH-1:0] serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic                  serdes_rx_valid,
  output logic                  rx_slip_done
);

  if (DATA_WIDTH != GB_DATA_W) begin : g_bad_data_width
    $error("eth_phy_10g_rx_gearbox: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != GB_HDR_W) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must be 2");
  end

  logic [BLOCK_W-1:0]    hold_q, hold_d;
  fill_t                 fill_q, fill_d;
  logic                  slip_prev_q, slip_prev_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic                  valid_q, valid_d;
  logic                  slip_done_q, slip_done_d;

  logic [GB_DATA_W-1:0]  word;
  logic                  slip;
  logic [COMB_W-1:0]     comb_raw, comb, rest;
  logic [TOT_W-1:0]      total;

  always_comb begin
    word        = BIT_REVERSE ? bit_rev(serdes_rx_data_in) : serdes_rx_data_in;
    slip        = serdes_rx_bitslip & ~slip_prev_q;
    // hold bits above fill are always zero, so a plain OR merges old and new bits
    comb_raw    = (COMB_W'(word) << fill_q) | COMB_W'(hold_q);
    comb        = slip ? (comb_raw >> 1) : comb_raw;
    total       = TOT_W'(fill_q) + TOT_W'(GB_DATA_W) - TOT_W'(slip);
    rest        = comb >> BLOCK_W;

    data_d      = data_q;
    hdr_d       = hdr_q;
    valid_d     = 1'b0;
    slip_done_d = slip;
    slip_prev_d = serdes_rx_bitslip;
    hold_d      = comb[BLOCK_W-1:0];
    fill_d      = FILL_W'(total);

    if (total >= TOT_W'(BLOCK_W)) begin
      valid_d = 1'b1;
      data_d  = comb[BLOCK_W-1:GB_HDR_W];
      hdr_d   = comb[GB_HDR_W-1:0];
      hold_d  = rest[BLOCK_W-1:0];
      fill_d  = FILL_W'(total - TOT_W'(BLOCK_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      fill_q      <= '0;
      slip_prev_q <= 1'b0;
      data_q      <= '0;
      hdr_q       <= '0;
      valid_q     <= 1'b0;
      slip_done_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      fill_q      <= fill_d;
      slip_prev_q <= slip_prev_d;
      data_q      <= data_d;
      hdr_q       <= hdr_d;
      valid_q     <= valid_d;
      slip_done_q <= slip_done_d;
    end
  end

  assign serdes_rx_data  = data_q;
  assign serdes_rx_hdr   = hdr_q;
  assign serdes_rx_valid = valid_q;
  assign rx_slip_done    = slip_done_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// Scoreboard bench: a bit-queue model predicts blocks; normal and bit-reversed DUTs checked together.
module tb_eth_phy_10g_rx_gearbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din = '0;
  logic [63:0] din_r;
  logic        bs = 1'b0;

  logic [63:0] d0_data, d1_data;
  logic [1:0]  d0_hdr, d1_hdr;
  logic        d0_valid, d1_valid, d0_sd, d1_sd;

  always #5 clk = ~clk;

  always_comb begin
    din_r = '0;
    for (int i = 0; i < 64; i++) din_r[i] = din[63-i];
  end

  eth_phy_10g_rx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .serdes_rx_data_in(din), .serdes_rx_bitslip(bs),
    .serdes_rx_data(d0_data), .serdes_rx_hdr(d0_hdr), .serdes_rx_valid(d0_valid),
    .rx_slip_done(d0_sd));

  eth_phy_10g_rx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .serdes_rx_data_in(din_r), .serdes_rx_bitslip(bs),
    .serdes_rx_data(d1_data), .serdes_rx_hdr(d1_hdr), .serdes_rx_valid(d1_valid),
    .rx_slip_done(d1_sd));

  typedef struct {bit v; bit sd;} cyc_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   src[$];
  bit   mq[$];
  bit   m_prev;
  cyc_t exp_cyc[$];
  logic [65:0] exp_blk[$];

  bit   mon_en = 0;
  bit   chk_aligned = 0;
  bit   chk_sync = 0;
  int   cyc_n, first_valid, valid_cnt, slip_seen, k_al;
  bit   vhist [0:511];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: a FIFO of received bits; a slip drops the oldest bit, 66 bits make a block
  task automatic model_step(input logic [63:0] w, input bit b);
    cyc_t e;
    logic [65:0] blk;
    bit sl;
    for (int i = 0; i < 64; i++) mq.push_back(w[i]);
    sl = b && !m_prev;
    m_prev = b;
    if (sl) void'(mq.pop_front());
    e.v = 0;
    e.sd = sl;
    if (mq.size() >= 66) begin
      for (int i = 0; i < 66; i++) blk[i] = mq.pop_front();
      exp_blk.push_back(blk);
      e.v = 1;
    end
    exp_cyc.push_back(e);
  endtask

  task automatic load_blocks(input int n, input int off);
    logic [65:0] blk;
    for (int j = 0; j < off; j++) src.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k < n; k++) begin
      blk = {64'h0123456789ABCDEF + 64'(k), 2'b10};
      for (int i = 0; i < 66; i++) src.push_back(blk[i]);
    end
  endtask

  task automatic step(input bit b);
    logic [63:0] w;
    @(negedge clk);
    for (int i = 0; i < 64; i++) w[i] = (src.size() > 0) ? src.pop_front() : 1'($urandom_range(0, 1));
    din = w;
    bs = b;
    model_step(w, b);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    mon_en = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en = 0;
    rst = 1'b1;
    #1;
    check("reset_out0", {12'd0, d0_data, d0_hdr, d0_valid, d0_sd}, 80'd0);
    check("reset_out1", {12'd0, d1_data, d1_hdr, d1_valid, d1_sd}, 80'd0);
    src.delete(); mq.delete(); exp_cyc.delete(); exp_blk.delete();
    m_prev = 0; din = '0; bs = 0;
    cyc_n = 0; first_valid = -1; valid_cnt = 0; slip_seen = 0; k_al = 0;
    chk_aligned = 0; chk_sync = 0;
    for (int i = 0; i < 512; i++) vhist[i] = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1;
  endtask

  initial begin : monitor
    cyc_t e;
    logic [65:0] blk;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && mon_en) begin
        if (exp_cyc.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL no_expectation: DUT clocked with no stimulus queued (t=%0t)", $time);
        end else begin
          e = exp_cyc.pop_front();
          cyc_n++;
          check("valid0", 80'(d0_valid), 80'(e.v));
          check("valid1", 80'(d1_valid), 80'(e.v));
          check("slip_done0", 80'(d0_sd), 80'(e.sd));
          check("slip_done1", 80'(d1_sd), 80'(e.sd));
          if (d0_sd) slip_seen++;
          if (cyc_n < 512) vhist[cyc_n] = d0_valid;
          if (e.v) begin
            if (first_valid < 0) first_valid = cyc_n;
            valid_cnt++;
            if (exp_blk.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL no_block: block expected but model queue empty");
            end else begin
              blk = exp_blk.pop_front();
              check("block0", 80'({d0_data, d0_hdr}), 80'(blk));
              check("block1", 80'({d1_data, d1_hdr}), 80'(blk));
            end
            if (chk_sync) check("sync_hdr", 80'(d0_hdr == 2'b10 || d0_hdr == 2'b01), 80'd1);
            if (chk_aligned) begin
              check("aligned_blk", 80'({d0_data, d0_hdr}),
                    80'({64'h0123456789ABCDEF + 64'(k_al), 2'b10}));
              k_al++;
            end
          end
        end
      end
    end
  end

  initial begin : driver
    int s0;
    // aligned stream and cadence
    do_reset();
    load_blocks(120, 0);
    chk_aligned = 1;
    repeat (99) step(0);
    drain();
    check("first_valid", 80'(first_valid), 80'd2);
    check("valid_count99", 80'(valid_cnt), 80'd96);
    check("gap_at_34", 80'(vhist[34]), 80'd0);
    check("gap_at_67", 80'(vhist[67]), 80'd0);

    // 5-bit offset recovered by 5 slip pulses
    do_reset();
    load_blocks(150, 5);
    for (int p = 0; p < 5; p++) begin
      step(1);
      repeat (8) step(0);
    end
    repeat (10) step(0);
    chk_sync = 1;
    repeat (60) step(0);
    drain();
    check("slip_pulses5", 80'(slip_seen), 80'd5);

    // bitslip held high: one slip only
    do_reset();
    load_blocks(60, 0);
    repeat (5) step(0);
    repeat (20) step(1);
    repeat (20) step(0);
    drain();
    check("slip_held_once", 80'(slip_seen), 80'd1);

    // slip when total would be exactly 66
    do_reset();
    load_blocks(100, 0);
    repeat (32) step(0);
    step(1);
    repeat (30) step(0);
    drain();
    check("no_valid_total66", 80'(vhist[33]), 80'd0);

    // slip right after the gap (fill = 0)
    do_reset();
    load_blocks(100, 0);
    repeat (33) step(0);
    step(1);
    repeat (30) step(0);
    drain();
    check("slip_fill0_done", 80'(slip_seen), 80'd1);

    // async reset mid-block (fill = 30), then cadence restarts
    do_reset();
    load_blocks(60, 0);
    repeat (18) step(0);
    drain();
    do_reset();
    load_blocks(60, 0);
    chk_aligned = 1;
    repeat (40) step(0);
    drain();
    check("first_valid_after_rst", 80'(first_valid), 80'd2);
    check("aligned_after_rst", 80'(k_al), 80'd38);

    // random data with random slip requests
    do_reset();
    s0 = 0;
    repeat (300) step(1'($urandom_range(0, 9) == 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
